// File: rtl/ps2_button_mapper.sv
// PS/2 keycode -> button mapper: run-time loadable keycode table scanned one entry per cycle,
// merged with joystick bits and optional 90-degree rotation. Define AUTOFIRE_EN for autofire on AF_BTN.
module ps2_button_mapper #(
    parameter int NUM_BTN = 8,
    parameter int NUM_ENT = 16,
    parameter int AF_DIV  = 200000,
    parameter int AF_BTN  = 4,
    localparam int AW = $clog2(NUM_ENT),
    localparam int BW = $clog2(NUM_BTN),
    localparam int DW = 11 + BW
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [10:0]        ps2_key,
    input  logic               tbl_we,
    input  logic [AW-1:0]      tbl_addr,
    input  logic [DW-1:0]      tbl_data,
    input  logic [NUM_BTN-1:0] joy_in,
    input  logic               rotate,
    input  logic               af_enable,
    output logic [NUM_BTN-1:0] btn_out,
    output logic               busy,
    output logic               dropped
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t                     state, state_n;
    logic [AW-1:0]              idx, idx_n;
    logic                       primed, old_tog, evt;
    logic [9:0]                 cur, pend;
    logic                       pend_full;
    logic                       take_evt, take_pend, pend_wr, pend_clr, drop_n;
    logic [NUM_ENT-1:0]         ent_valid, ent_any, ent_state;
    logic [NUM_ENT-1:0][8:0]    ent_code;
    logic [NUM_ENT-1:0][BW-1:0] ent_btn;
    logic                       hit;
    logic [NUM_BTN-1:0]         raw, rot, nxt;

    assign evt  = primed && (ps2_key[10] != old_tog);
    assign busy = (state == SCAN);
    assign hit  = busy && ent_valid[idx] && (ent_code[idx][7:0] == cur[7:0]) &&
                  (ent_any[idx] || (ent_code[idx][8] == cur[8]));

    // The first cycle out of reset only learns the toggle level, so a stale toggle is not an event.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            primed  <= 1'b0;
            old_tog <= 1'b0;
        end else begin
            primed  <= 1'b1;
            old_tog <= ps2_key[10];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        take_evt  = 1'b0;
        take_pend = 1'b0;
        pend_wr   = 1'b0;
        pend_clr  = 1'b0;
        drop_n    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_full) begin
                    take_pend = 1'b1;
                    state_n   = SCAN;
                    idx_n     = '0;
                    if (evt) pend_wr = 1'b1;
                    else     pend_clr = 1'b1;
                end else if (evt) begin
                    take_evt = 1'b1;
                    state_n  = SCAN;
                    idx_n    = '0;
                end
            end
            SCAN: begin
                if (idx == AW'(NUM_ENT - 1)) state_n = IDLE;
                else                         idx_n   = idx + 1'b1;
                if (evt) begin
                    if (pend_full) drop_n  = 1'b1;
                    else           pend_wr = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            cur       <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            idx     <= idx_n;
            dropped <= drop_n;
            if (take_pend)     cur <= pend;
            else if (take_evt) cur <= ps2_key[9:0];
            if (pend_wr) begin
                pend      <= ps2_key[9:0];
                pend_full <= 1'b1;
            end else if (pend_clr) begin
                pend_full <= 1'b0;
            end
        end
    end

    // Table write is applied after the scan update so it wins on a same-entry collision.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            ent_any   <= '0;
            ent_code  <= '0;
            ent_btn   <= '0;
            ent_state <= '0;
        end else begin
            if (hit) ent_state[idx] <= cur[9];
            if (tbl_we) begin
                ent_valid[tbl_addr] <= tbl_data[DW-1];
                ent_any[tbl_addr]   <= tbl_data[DW-2];
                ent_code[tbl_addr]  <= tbl_data[BW+8:BW];
                ent_btn[tbl_addr]   <= tbl_data[BW-1:0];
                ent_state[tbl_addr] <= 1'b0;
            end
        end
    end

    always_comb begin
        raw = joy_in;
        for (int b = 0; b < NUM_BTN; b++)
            for (int i = 0; i < NUM_ENT; i++)
                if (ent_valid[i] && ent_state[i] && (ent_btn[i] == BW'(b))) raw[b] = 1'b1;
    end

    always_comb begin
        rot = raw;
        if (rotate) begin
            rot[3] = raw[1];
            rot[2] = raw[0];
            rot[1] = raw[2];
            rot[0] = raw[3];
        end
    end

`ifdef AUTOFIRE_EN
    localparam int CW = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
    logic [CW-1:0] af_cnt;
    logic          af_phase, af_act;

    assign af_act = af_enable && raw[AF_BTN];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (!af_act) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt == CW'(AF_DIV - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt = rot;
        if (af_enable) nxt[AF_BTN] = af_act && !af_phase;
    end
`else
    logic unused_af;
    assign unused_af = af_enable;
    assign nxt = rot;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) btn_out <= '0;
        else       btn_out <= nxt;
    end
endmodule

// File: tb/tb_ps2_button_mapper.sv
// Scoreboard bench for ps2_button_mapper: stimulus pushes expected btn_out from a
// table/key-state model, a negedge monitor pops and compares.
module tb_ps2_button_mapper;
    localparam int NB = 8, NE = 16, AFD = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [10:0] ps2_key;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [13:0] tbl_data;
    logic [7:0]  joy_in;
    logic        rotate, af_enable;
    logic [7:0]  btn_out;
    logic        busy, dropped;

    ps2_button_mapper #(.NUM_BTN(NB), .NUM_ENT(NE), .AF_DIV(AFD), .AF_BTN(4)) dut (
        .clk_sys(clk), .reset(rst), .ps2_key(ps2_key), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .joy_in(joy_in), .rotate(rotate), .af_enable(af_enable),
        .btn_out(btn_out), .busy(busy), .dropped(dropped));

    always #5 clk = ~clk;

    int         total = 0, bad = 0, drop_cnt = 0;
    logic [7:0] exp_q[$];
    logic       sample_req = 1'b0;

    // reference model: table contents, per-entry key state, joystick/rotate
    bit         m_valid[NE], m_any[NE], m_st[NE];
    logic [8:0] m_code[NE];
    int         m_btn[NE];
    logic [7:0] m_joy;
    bit         m_rot;
    logic       tog;
    logic [8:0] pool[8] = '{9'h029, 9'h129, 9'h014, 9'h114, 9'h075, 9'h175, 9'h06B, 9'h16B};

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [7:0] r;
        r = m_joy;
        for (int i = 0; i < NE; i++)
            if (m_valid[i] && m_st[i] && m_btn[i] < NB) r[m_btn[i]] = 1'b1;
        if (m_rot) return {r[7:4], r[1], r[0], r[2], r[3]};
        return r;
    endfunction

    function automatic void model_key(bit p, logic [8:0] c);
        for (int i = 0; i < NE; i++)
            if (m_valid[i] && m_code[i][7:0] == c[7:0] && (m_any[i] || m_code[i][8] == c[8]))
                m_st[i] = p;
    endfunction

    always @(negedge clk) begin
        if (dropped) drop_cnt++;
        if (sample_req) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard: sample with empty queue at %0t", $time);
            end else begin
                check("btn_out", btn_out, exp_q.pop_front());
            end
        end
    end

    task automatic expect_now();
        exp_q.push_back(model_out());
        sample_req = 1'b1;
        @(negedge clk);
        #1 sample_req = 1'b0;
    endtask

    task automatic toggle_key(bit p, logic [8:0] c);
        tog = ~tog;
        ps2_key = {tog, p, c};
    endtask

    task automatic send_key(bit p, logic [8:0] c);
        @(posedge clk); #1;
        toggle_key(p, c);
        model_key(p, c);
        repeat (NE + 3) @(posedge clk);
        expect_now();
    endtask

    task automatic write_ent(int e, bit v, bit a, logic [8:0] c, int b);
        @(posedge clk); #1;
        tbl_we = 1'b1; tbl_addr = e[3:0]; tbl_data = {v, a, c, b[2:0]};
        @(posedge clk); #1;
        tbl_we = 1'b0;
        m_valid[e] = v; m_any[e] = a; m_code[e] = c; m_btn[e] = b; m_st[e] = 1'b0;
        @(posedge clk);
        expect_now();
    endtask

    task automatic set_joy(logic [7:0] j, bit r);
        @(posedge clk); #1;
        joy_in = j; rotate = r; m_joy = j; m_rot = r;
        @(posedge clk);
        expect_now();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        bit afx;
        tog = 1'b1; ps2_key = 11'h400;
        tbl_we = 0; tbl_addr = 0; tbl_data = 0; joy_in = 0; rotate = 0; af_enable = 0;
        m_joy = 0; m_rot = 0;
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0; m_any[i] = 0; m_st[i] = 0; m_code[i] = 0; m_btn[i] = 0;
        end

        // reset with toggle high, then release: no event must be generated
        repeat (3) @(posedge clk);
        #1 check("reset_busy", busy, 0);
        check("reset_dropped", dropped, 0);
        expect_now();
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("no_event_after_reset", busy, 0);
        expect_now();

        // single key, latency bound
        write_ent(0, 1, 0, 9'h029, 4);
        send_key(1, 9'h029);
        send_key(0, 9'h029);

        // two keys on one button are tracked independently
        write_ent(1, 1, 0, 9'h014, 4);
        send_key(1, 9'h029);
        send_key(1, 9'h014);
        send_key(0, 9'h014);
        send_key(0, 9'h029);

        // autofire pattern (or pass-through when the feature is absent)
        @(posedge clk); #1 af_enable = 1'b1;
        toggle_key(1, 9'h029); model_key(1, 9'h029);
        n = 0;
        while (!btn_out[4] && n < NE + 4) begin @(posedge clk); #1 n++; end
        check("af_rise_in_time", (n < NE + 4), 1);
        for (int i = 0; i < 16; i++) begin
`ifdef AUTOFIRE_EN
            afx = ((i / AFD) % 2) == 0;
`else
            afx = 1'b1;
`endif
            check("af_pattern", btn_out[4], afx);
            @(posedge clk); #1;
        end
        send_key(0, 9'h029);
        @(posedge clk); #1 af_enable = 1'b0;

        // anyext matching
        write_ent(5, 1, 1, 9'h075, 3);
        send_key(1, 9'h075);
        send_key(0, 9'h075);
        send_key(1, 9'h175);
        send_key(0, 9'h175);
        write_ent(5, 1, 0, 9'h075, 3);
        send_key(1, 9'h175);
        send_key(1, 9'h075);
        send_key(0, 9'h075);

        // three toggles back-to-back: first two applied, third dropped
        write_ent(2, 1, 0, 9'h01C, 5);
        write_ent(3, 1, 0, 9'h01B, 6);
        write_ent(4, 1, 0, 9'h023, 7);
        d0 = drop_cnt;
        @(posedge clk); #1 toggle_key(1, 9'h01C); model_key(1, 9'h01C);
        @(posedge clk); #1 check("busy_in_scan", busy, 1);
        toggle_key(1, 9'h01B); model_key(1, 9'h01B);
        @(posedge clk); #1 toggle_key(1, 9'h023);
        repeat (2 * NE + 6) @(posedge clk);
        expect_now();
        check("dropped_once", drop_cnt - d0, 1);

        // event landing in the final scan cycle goes to pending, not lost
        d0 = drop_cnt;
        @(posedge clk); #1 toggle_key(1, 9'h023); model_key(1, 9'h023);
        repeat (NE) @(posedge clk);
        #1 toggle_key(0, 9'h01B); model_key(0, 9'h01B);
        repeat (2 * NE + 6) @(posedge clk);
        expect_now();
        check("no_drop_at_scan_end", drop_cnt - d0, 0);
        send_key(0, 9'h01C);
        send_key(0, 9'h023);

        // joystick and rotation
        set_joy(8'h02, 1);
        set_joy(8'h02, 0);
        set_joy(8'h09, 1);
        set_joy(8'h00, 0);

        // randomized mix
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1: write_ent($urandom_range(0, NE - 1), $urandom_range(0, 3) != 0,
                                $urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)],
                                $urandom_range(0, NB - 1));
                8:       set_joy(8'($urandom), m_rot);
                9:       set_joy(m_joy, ~m_rot);
                default: send_key($urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)]);
            endcase
        end

        repeat (5) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
